// File: rtl/iob_arb_pkg.sv
// Shared definitions for the two-master IOb arbiter: default bus widths,
// packed-field bit positions and the master identifier type.
package iob_arb_pkg;

    localparam int IOB_ADDR_W = 32;
    localparam int IOB_DATA_W = 32;
    localparam int IOB_STRB_W = IOB_DATA_W / 8;
    localparam int IOB_REQ_W  = 1 + IOB_ADDR_W + IOB_DATA_W + IOB_STRB_W;
    localparam int IOB_RESP_W = IOB_DATA_W + 2;

    // Field slices of {avalid, addr, wdata, wstrb} and {rdata, rvalid, ready}
    localparam int AVALID_BIT = IOB_REQ_W - 1;
    localparam int ADDR_MSB   = IOB_REQ_W - 2;
    localparam int ADDR_LSB   = IOB_DATA_W + IOB_STRB_W;
    localparam int WDATA_MSB  = IOB_DATA_W + IOB_STRB_W - 1;
    localparam int WDATA_LSB  = IOB_STRB_W;
    localparam int WSTRB_MSB  = IOB_STRB_W - 1;
    localparam int WSTRB_LSB  = 0;
    localparam int RDATA_MSB  = IOB_RESP_W - 1;
    localparam int RDATA_LSB  = 2;
    localparam int RVALID_BIT = 1;
    localparam int READY_BIT  = 0;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } mst_id_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iob_arb_id_fifo.sv
// Small FIFO of master IDs, one entry per read accepted by the slave,
// so in-order read responses can be steered back to their issuer.
module iob_arb_id_fifo
    import iob_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    arst_n,
    input  logic    push,
    input  mst_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output mst_id_t head
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    mst_id_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Entry storage and write pointer
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= MST_0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_id;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
        end
    end

    // Read pointer and occupancy; push+pop together keeps the count
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/iob_bus_arbiter2.sv
// Two-master to one-slave IOb arbiter: round-robin grant with request locking,
// read-response routing through an ID FIFO, and a sticky spurious-rvalid flag.
module iob_bus_arbiter2
    import iob_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_RD = 2,
    parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
    parameter int RESP_W = DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic [REQ_W-1:0]  m0_req_i,
    output logic [RESP_W-1:0] m0_resp_o,
    input  logic [REQ_W-1:0]  m1_req_i,
    output logic [RESP_W-1:0] m1_resp_o,
    output logic [REQ_W-1:0]  s_req_o,
    input  logic [RESP_W-1:0] s_resp_i,
    output logic              err_o
);

    localparam int STRB_W = DATA_W / 8;

    mst_id_t          grant_s;
    mst_id_t          last_grant_r;
    mst_id_t          lock_id_r;
    logic             lock_r;
    logic             err_r;
    logic [REQ_W-1:0] gnt_req_s;
    logic             gnt_valid_s;
    logic             gnt_read_s;
    logic             stall_s;
    logic             fwd_s;
    logic             accept_s;
    logic             rsp_valid_s;
    logic             m0_avalid_s;
    logic             m1_avalid_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    mst_id_t          fifo_head_s;

    assign m0_avalid_s = m0_req_i[REQ_W-1];
    assign m1_avalid_s = m1_req_i[REQ_W-1];

    // Grant selection: a locked master keeps the bus, otherwise round-robin on ties
    always_comb begin
        grant_s = MST_0;
        if (lock_r) begin
            grant_s = lock_id_r;
        end else if (m0_avalid_s && m1_avalid_s) begin
            grant_s = (last_grant_r == MST_0) ? MST_1 : MST_0;
        end else if (m1_avalid_s) begin
            grant_s = MST_1;
        end else begin
            grant_s = MST_0;
        end
    end

    // Forward the granted request unless it is a read with no FIFO room
    always_comb begin
        gnt_req_s   = (grant_s == MST_1) ? m1_req_i : m0_req_i;
        gnt_valid_s = gnt_req_s[REQ_W-1];
        gnt_read_s  = (gnt_req_s[STRB_W-1:0] == {STRB_W{1'b0}});
        stall_s     = gnt_valid_s & gnt_read_s & fifo_full_s;
        fwd_s       = gnt_valid_s & ~stall_s;
        accept_s    = fwd_s & s_resp_i[0];
        if (fwd_s) begin
            s_req_o = gnt_req_s;
        end else begin
            s_req_o = {REQ_W{1'b0}};
        end
    end

    // Response demux: rdata broadcast, rvalid to FIFO head, ready to the granted master
    always_comb begin
        rsp_valid_s = s_resp_i[1] & ~fifo_empty_s;
        m0_resp_o   = {s_resp_i[RESP_W-1:2],
                       rsp_valid_s & (fifo_head_s == MST_0),
                       accept_s & (grant_s == MST_0)};
        m1_resp_o   = {s_resp_i[RESP_W-1:2],
                       rsp_valid_s & (fifo_head_s == MST_1),
                       accept_s & (grant_s == MST_1)};
    end

    // Lock and round-robin history
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_r       <= 1'b0;
            lock_id_r    <= MST_0;
            last_grant_r <= MST_1;
        end else if (cke_i) begin
            if (accept_s) begin
                lock_r       <= 1'b0;
                last_grant_r <= grant_s;
            end else if (gnt_valid_s) begin
                lock_r    <= 1'b1;
                lock_id_r <= grant_s;
            end
        end
    end

    // Sticky flag for rvalid arriving with nothing outstanding
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_r <= 1'b0;
        end else if (cke_i && s_resp_i[1] && fifo_empty_s) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;

    iob_arb_id_fifo #(
        .DEPTH (MAX_RD)
    ) u_id_fifo (
        .clk     (clk_i),
        .arst_n  (arst_n_i),
        .push    (cke_i & accept_s & gnt_read_s),
        .push_id (grant_s),
        .pop     (cke_i & rsp_valid_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s)
    );

endmodule
